// File: rtl/pushbox_pkg.sv
// PushBox key command shared definitions.
// Scan codes, command/direction encodings and held-mask bit indices.
package pushbox_pkg;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_Z     = 8'h1A;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      CMD_MOVE    = 2'd0,
      CMD_RESTART = 2'd1,
      CMD_UNDO    = 2'd2,
      CMD_RSVD    = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   localparam int HB_UP      = 0;
   localparam int HB_DOWN    = 1;
   localparam int HB_LEFT    = 2;
   localparam int HB_RIGHT   = 3;
   localparam int HB_RESTART = 4;
   localparam int HB_UNDO    = 5;
   localparam int HB_N       = 6;

   typedef struct packed {
      logic            hit;
      logic [HB_N-1:0] bit_m;
      cmd_e            ctype;
      dir_e            dir;
   } key_dec_t;

   function automatic key_dec_t decode_key(input logic [8:0] kc);
      key_dec_t d;
      d.hit   = 1'b0;
      d.bit_m = '0;
      d.ctype = CMD_MOVE;
      d.dir   = DIR_UP;
      if (!kc[8]) begin
         unique case (kc[7:0])
            SC_W: begin
               d.hit = 1'b1;
               d.bit_m[HB_UP] = 1'b1;
            end
            SC_S: begin
               d.hit = 1'b1;
               d.bit_m[HB_DOWN] = 1'b1;
               d.dir = DIR_DOWN;
            end
            SC_A: begin
               d.hit = 1'b1;
               d.bit_m[HB_LEFT] = 1'b1;
               d.dir = DIR_LEFT;
            end
            SC_D: begin
               d.hit = 1'b1;
               d.bit_m[HB_RIGHT] = 1'b1;
               d.dir = DIR_RIGHT;
            end
            SC_R: begin
               d.hit = 1'b1;
               d.bit_m[HB_RESTART] = 1'b1;
               d.ctype = CMD_RESTART;
            end
            SC_Z: begin
               d.hit = 1'b1;
               d.bit_m[HB_UNDO] = 1'b1;
               d.ctype = CMD_UNDO;
            end
            default: ;
         endcase
      end else begin
         unique case (kc[7:0])
            SC_UP: begin
               d.hit = 1'b1;
               d.bit_m[HB_UP] = 1'b1;
            end
            SC_DOWN: begin
               d.hit = 1'b1;
               d.bit_m[HB_DOWN] = 1'b1;
               d.dir = DIR_DOWN;
            end
            SC_LEFT: begin
               d.hit = 1'b1;
               d.bit_m[HB_LEFT] = 1'b1;
               d.dir = DIR_LEFT;
            end
            SC_RIGHT: begin
               d.hit = 1'b1;
               d.bit_m[HB_RIGHT] = 1'b1;
               d.dir = DIR_RIGHT;
            end
            default: ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/ps2_key_repeat_timer.sv
// Auto-repeat timer: first pulse after REPEAT_DELAY cycles of a held
// key, then one pulse every REPEAT_PERIOD cycles while run stays high.
module ps2_key_repeat_timer #(
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   parameter int unsigned CNT_W         = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic pulse
);

   localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] cnt;
   logic             rep_ph;

   assign pulse = run && !restart &&
                  (cnt == (rep_ph ? PER_M1 : DLY_M1));

   // The key event cycle itself is count 0, so the register resumes at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         rep_ph <= 1'b0;
      end else if (restart) begin
         cnt    <= CNT_W'(1);
         rep_ph <= 1'b0;
      end else if (!run) begin
         cnt    <= '0;
         rep_ph <= 1'b0;
      end else if (pulse) begin
         cnt    <= '0;
         rep_ph <= 1'b1;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ps2_key_cmd.sv
// PS/2 key events to PushBox commands with a one-deep valid/ready slot.
// Optional auto-repeat when PS2_KEY_CMD_AUTO_REPEAT_EN is defined.
module ps2_key_cmd
   import pushbox_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   parameter int unsigned CNT_W         = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] key_code,
   input  logic       key_ready,
   output logic       cmd_valid,
   output logic [1:0] cmd_type,
   output logic [1:0] cmd_dir,
   input  logic       cmd_ready,
   output logic       overflow
);

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   state_e          state, state_nxt;
   cmd_e            type_q, ld_type;
   dir_e            dir_q, ld_dir, rep_dir;
   logic            ovf_q, ovf_set, load;
   logic [HB_N-1:0] held, held_nxt;
   key_dec_t        dec;
   logic            key_hit, gen_cmd, rep_fire, new_cmd;

   assign dec     = decode_key(key_code[8:0]);
   assign key_hit = key_ready && dec.hit;
   assign gen_cmd = key_hit && !key_code[9] &&
                    ((held & dec.bit_m) == '0);
   assign new_cmd = gen_cmd || rep_fire;

   always_comb begin
      held_nxt = held;
      if (key_hit) begin
         if (key_code[9]) held_nxt = held & ~dec.bit_m;
         else             held_nxt = held | dec.bit_m;
      end
   end

`ifdef PS2_KEY_CMD_AUTO_REPEAT_EN
   logic run, restart, pulse;

   assign run     = $onehot(held[HB_RIGHT:HB_UP]);
   assign restart = (held_nxt != held);

   ps2_key_repeat_timer #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .restart (restart),
      .pulse   (pulse)
   );

   // A key event in the same cycle always takes priority over a repeat.
   assign rep_fire = pulse && !key_ready;

   always_comb begin
      rep_dir = DIR_UP;
      unique case (1'b1)
         held[HB_DOWN]:  rep_dir = DIR_DOWN;
         held[HB_LEFT]:  rep_dir = DIR_LEFT;
         held[HB_RIGHT]: rep_dir = DIR_RIGHT;
         default:        rep_dir = DIR_UP;
      endcase
   end
`else
   logic unused_cfg;

   assign rep_fire   = 1'b0;
   assign rep_dir    = DIR_UP;
   assign unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0], CNT_W[0]};
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ovf_set   = 1'b0;
      ld_type   = gen_cmd ? dec.ctype : CMD_MOVE;
      ld_dir    = gen_cmd ? dec.dir : rep_dir;
      unique case (state)
         ST_EMPTY: begin
            if (new_cmd) begin
               load      = 1'b1;
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (cmd_ready) begin
               if (new_cmd) load = 1'b1;
               else         state_nxt = ST_EMPTY;
            end else if (gen_cmd) begin
               // Dropped repeats stay silent; only real keys flag overflow.
               ovf_set = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_EMPTY;
         type_q <= CMD_MOVE;
         dir_q  <= DIR_UP;
         ovf_q  <= 1'b0;
         held   <= '0;
      end else begin
         state <= state_nxt;
         held  <= held_nxt;
         if (load) begin
            type_q <= ld_type;
            dir_q  <= ld_dir;
         end
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   assign cmd_valid = (state == ST_FULL);
   assign cmd_type  = type_q;
   assign cmd_dir   = dir_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_cmd.sv
// Bench for ps2_key_cmd: directed vector table, async reset,
// random traffic against a slot/queue reference model.
module tb_ps2_key_cmd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] key_code = '0;
   logic       key_ready = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid, overflow;
   logic [1:0] cmd_type, cmd_dir;

   int errs = 0;
   int checks = 0;

   ps2_key_cmd #(
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4),
      .CNT_W         (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_code  (key_code),
      .key_ready (key_ready),
      .cmd_valid (cmd_valid),
      .cmd_type  (cmd_type),
      .cmd_dir   (cmd_dir),
      .cmd_ready (cmd_ready),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rs;
      bit         kr;
      logic [9:0] kc;
      bit         rdy;
      bit         v;
      logic [1:0] t;
      logic [1:0] d;
      bit         o;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [9:0] act,
                      input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input bit rs, input bit kr, input logic [9:0] kc,
                      input bit rdy, input bit v, input logic [1:0] t,
                      input logic [1:0] d, input bit o);
      vec_t e;
      e.rs = rs; e.kr = kr; e.kc = kc; e.rdy = rdy;
      e.v = v; e.t = t; e.d = d; e.o = o;
      tbl.push_back(e);
   endtask

   task automatic step(input bit rs, input bit kr, input logic [9:0] kc,
                       input bit rdy);
      rst = rs;
      key_ready = kr;
      key_code = kc;
      cmd_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Reference model: held keys as a set, the slot as a depth-1 queue.
   logic [8:0] map_code[10] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h02D,
                                9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174};
   int         map_id[10]   = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
   bit         m_held[6];
   logic [3:0] m_slot[$];
   bit         m_ovf;

   function automatic int lookup(input logic [8:0] c);
      for (int i = 0; i < 10; i++)
         if (map_code[i] == c) return map_id[i];
      return -1;
   endfunction

   task automatic model_reset();
      foreach (m_held[i]) m_held[i] = 1'b0;
      m_slot.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_step(input bit kr, input logic [9:0] kc,
                             input bit rdy);
      int id;
      logic [1:0] t, d;
      bit fresh;
      fresh = 1'b0;
      id = lookup(kc[8:0]);
      if (kr && id >= 0) begin
         if (kc[9]) m_held[id] = 1'b0;
         else if (!m_held[id]) begin
            m_held[id] = 1'b1;
            fresh = 1'b1;
         end
      end
      if (m_slot.size() != 0 && rdy) void'(m_slot.pop_front());
      if (fresh) begin
         t = (id < 4) ? 2'd0 : (id == 4) ? 2'd1 : 2'd2;
         d = (id < 4) ? 2'(id) : 2'd0;
         if (m_slot.size() == 0) m_slot.push_back({t, d});
         else m_ovf = 1'b1;
      end
   endtask

   task automatic model_cmp();
      logic [3:0] p;
      chk("rnd_valid", 10'(cmd_valid), 10'(m_slot.size() != 0));
      chk("rnd_ovf", 10'(overflow), 10'(m_ovf));
      if (m_slot.size() != 0) begin
         p = m_slot[0];
         chk("rnd_payload", 10'({cmd_type, cmd_dir}), 10'(p));
      end
   endtask

   logic [8:0] pool[13] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h02D,
                            9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174,
                            9'h005, 9'h075, 9'h11D};

   initial begin
      bit         kr, rdy;
      logic [9:0] kc;
      int         bias;

      rst = 1'b1;
      #12;
      chk("rst_valid", 10'(cmd_valid), 10'd0);
      chk("rst_type", 10'(cmd_type), 10'd0);
      chk("rst_dir", 10'(cmd_dir), 10'd0);
      chk("rst_ovf", 10'(overflow), 10'd0);
      @(posedge clk);
      #1;

      //  rs kr code     rdy v  t  d  o
      add(0, 1, 10'h01D, 1, 1, 0, 0, 0);
      add(0, 0, 10'h000, 1, 0, 0, 0, 0);
      add(0, 1, 10'h21D, 1, 0, 0, 0, 0);
      add(0, 0, 10'h000, 1, 0, 0, 0, 0);
      add(0, 1, 10'h175, 1, 1, 0, 0, 0);
      add(0, 1, 10'h175, 1, 0, 0, 0, 0);
      add(0, 1, 10'h175, 1, 0, 0, 0, 0);
      add(0, 1, 10'h375, 1, 0, 0, 0, 0);
      add(0, 1, 10'h175, 1, 1, 0, 0, 0);
      add(0, 0, 10'h000, 1, 0, 0, 0, 0);
      add(0, 1, 10'h375, 1, 0, 0, 0, 0);
      add(0, 1, 10'h01C, 0, 1, 0, 2, 0);
      add(0, 1, 10'h023, 0, 1, 0, 2, 1);
      add(0, 0, 10'h000, 0, 1, 0, 2, 1);
      add(0, 0, 10'h000, 1, 0, 0, 0, 1);
      add(1, 0, 10'h000, 0, 0, 0, 0, 0);
      add(0, 0, 10'h000, 0, 0, 0, 0, 0);
      add(0, 1, 10'h02D, 0, 1, 1, 0, 0);
      add(0, 1, 10'h01A, 1, 1, 2, 0, 0);
      add(0, 0, 10'h000, 1, 0, 0, 0, 0);
      add(0, 1, 10'h005, 1, 0, 0, 0, 0);
      add(0, 1, 10'h075, 1, 0, 0, 0, 0);
      add(0, 1, 10'h11D, 1, 0, 0, 0, 0);
      add(0, 1, 10'h223, 1, 0, 0, 0, 0);
      add(0, 1, 10'h21A, 1, 0, 0, 0, 0);
      add(0, 1, 10'h01A, 1, 1, 2, 0, 0);
      add(0, 1, 10'h172, 1, 1, 0, 1, 0);
      add(0, 1, 10'h16B, 1, 1, 0, 2, 0);
      add(0, 1, 10'h174, 1, 1, 0, 3, 0);
      add(0, 0, 10'h000, 1, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rs, tbl[i].kr, tbl[i].kc, tbl[i].rdy);
         chk($sformatf("vec%0d_valid", i), 10'(cmd_valid), 10'(tbl[i].v));
         chk($sformatf("vec%0d_ovf", i), 10'(overflow), 10'(tbl[i].o));
         if (tbl[i].v) begin
            chk($sformatf("vec%0d_type", i), 10'(cmd_type), 10'(tbl[i].t));
            chk($sformatf("vec%0d_dir", i), 10'(cmd_dir), 10'(tbl[i].d));
         end
      end

      // Async reset with a command pending and overflow set.
      step(1, 0, 10'h000, 0);
      step(0, 1, 10'h01B, 0);
      step(0, 1, 10'h01C, 0);
      chk("pre_arst_valid", 10'(cmd_valid), 10'd1);
      chk("pre_arst_dir", 10'(cmd_dir), 10'd1);
      chk("pre_arst_ovf", 10'(overflow), 10'd1);
      key_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 10'(cmd_valid), 10'd0);
      chk("arst_type", 10'(cmd_type), 10'd0);
      chk("arst_dir", 10'(cmd_dir), 10'd0);
      chk("arst_ovf", 10'(overflow), 10'd0);

`ifdef PS2_KEY_CMD_AUTO_REPEAT_EN
      step(1, 0, 10'h000, 1);
      step(0, 1, 10'h023, 1);
      chk("ar_first", 10'({cmd_valid, cmd_type, cmd_dir}), 10'b1_00_11);
      for (int i = 1; i <= 20; i++) begin
         step(0, 0, 10'h000, 1);
         chk($sformatf("ar_t%0d", i), 10'(cmd_valid),
             10'(i == 7 || i == 11 || i == 15 || i == 19));
         if (i == 7) chk("ar_dir", 10'(cmd_dir), 10'd3);
      end
      step(0, 1, 10'h01D, 1);
      chk("ar_up", 10'({cmd_valid, cmd_type, cmd_dir}), 10'b1_00_00);
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 10'h000, 1);
         chk($sformatf("ar_stop%0d", i), 10'(cmd_valid), 10'd0);
      end
`else
      // Holding a direction with no break yields nothing further.
      step(1, 0, 10'h000, 1);
      step(0, 1, 10'h023, 1);
      chk("hold_first", 10'({cmd_valid, cmd_type, cmd_dir}), 10'b1_00_11);
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 10'h000, 1);
         chk($sformatf("hold%0d", i), 10'(cmd_valid), 10'd0);
      end

      for (int ep = 0; ep < 8; ep++) begin
         step(1, 0, 10'h000, 0);
         model_reset();
         bias = (ep % 2 == 0) ? 3 : 1;
         for (int c = 0; c < 300; c++) begin
            kr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) kc = 10'($urandom);
            else kc = {($urandom_range(0, 2) == 0),
                       pool[$urandom_range(0, 12)]};
            rdy = ($urandom_range(0, 3) < bias);
            model_step(kr, kc, rdy);
            step(0, kr, kc, rdy);
            model_cmp();
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
